// File: rtl/ysyx_22050710_axil_sram.sv
// AXI-lite slave SRAM: register-array memory with byte-strobed writes,
// configurable read latency and SLVERR outside [BASE_ADDR, BASE_ADDR + DEPTH*STRB_WIDTH).
module ysyx_22050710_axil_sram #(
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int                    DEPTH        = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h8000_0000,
  parameter int                    READ_LATENCY = 1
) (
  input  logic                  i_aclk,
  input  logic                  i_arst,
  // Handshakes: a beat transfers on a rising edge where valid && ready;
  // valid never waits on ready, and the slave holds its response until taken.
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic [2:0]            i_awprot,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_WIDTH-1:0] i_wstrb,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic [1:0]            o_bresp,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [2:0]            i_arprot,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_dbg_wstate,
  output logic [1:0]            o_dbg_rstate
);

  localparam int                  OFF_BITS = $clog2(STRB_WIDTH);
  localparam int                  IDX_BITS = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH + 1)'(DEPTH * STRB_WIDTH);
  localparam logic [1:0]          RESP_OKAY   = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic prot_unused;
  assign prot_unused = ^{i_awprot, i_arprot};

  // ---------------- write channel ----------------
  w_state_t              w_state;
  logic                  aw_captured, w_captured;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  aw_hs, w_hs, wr_commit, wr_ok;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_off;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [IDX_BITS-1:0]   wr_idx;

  assign o_awready    = (w_state == W_IDLE) && !aw_captured;
  assign o_wready     = (w_state == W_IDLE) && !w_captured;
  assign o_dbg_wstate = w_state;
  assign aw_hs        = i_awvalid && o_awready;
  assign w_hs         = i_wvalid && o_wready;

  // A handshake landing this cycle counts as captured for the commit.
  assign wr_addr   = aw_captured ? aw_addr_q : i_awaddr;
  assign wr_data   = w_captured ? w_data_q : i_wdata;
  assign wr_strb   = w_captured ? w_strb_q : i_wstrb;
  assign wr_commit = (w_state == W_IDLE) && (aw_captured || aw_hs) && (w_captured || w_hs);
  assign wr_off    = wr_addr - BASE_ADDR;
  assign wr_ok     = (wr_addr >= BASE_ADDR) && ({1'b0, wr_off} < SPAN);
  assign wr_idx    = IDX_BITS'(wr_off >> OFF_BITS);

  always_ff @(posedge i_aclk) begin
    if (i_arst) begin
      w_state     <= W_IDLE;
      aw_captured <= 1'b0;
      w_captured  <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      o_bvalid    <= 1'b0;
      o_bresp     <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_captured <= 1'b1;
            aw_addr_q   <= i_awaddr;
          end
          if (w_hs) begin
            w_captured <= 1'b1;
            w_data_q   <= i_wdata;
            w_strb_q   <= i_wstrb;
          end
          if (wr_commit) begin
            w_state  <= W_RESP;
            o_bvalid <= 1'b1;
            o_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        W_RESP: begin
          if (i_bready) begin
            w_state     <= W_IDLE;
            o_bvalid    <= 1'b0;
            o_bresp     <= RESP_OKAY;
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Memory is never reset; a commit coinciding with reset is suppressed.
  always_ff @(posedge i_aclk) begin
    if (!i_arst && wr_commit && wr_ok) begin
      for (int k = 0; k < STRB_WIDTH; k++) begin
        if (wr_strb[k]) mem[wr_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t              r_state;
  logic [1:0]            r_cnt;
  logic                  ar_hs, rd_ok;
  logic [ADDR_WIDTH-1:0] rd_off;
  logic [IDX_BITS-1:0]   rd_idx;

  assign o_arready    = (r_state == R_IDLE);
  assign o_dbg_rstate = r_state;
  assign ar_hs        = i_arvalid && o_arready;
  assign rd_off       = i_araddr - BASE_ADDR;
  assign rd_ok        = (i_araddr >= BASE_ADDR) && ({1'b0, rd_off} < SPAN);
  assign rd_idx       = IDX_BITS'(rd_off >> OFF_BITS);

  // Data is sampled on the ar edge, so a same-edge write commit is not seen.
  always_ff @(posedge i_aclk) begin
    if (i_arst) begin
      r_state  <= R_IDLE;
      r_cnt    <= '0;
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
      o_rresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            o_rdata <= rd_ok ? mem[rd_idx] : '0;
            o_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            if (READ_LATENCY == 1) begin
              r_state  <= R_RESP;
              o_rvalid <= 1'b1;
            end else begin
              r_state <= R_WAIT;
              r_cnt   <= 2'(READ_LATENCY - 1);
            end
          end
        end
        R_WAIT: begin
          if (r_cnt == 2'd1) begin
            r_state  <= R_RESP;
            r_cnt    <= '0;
            o_rvalid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        R_RESP: begin
          if (i_rready) begin
            r_state  <= R_IDLE;
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
            o_rresp  <= RESP_OKAY;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_axil_sram.sv
// Directed bench for the AXI-lite SRAM: one instance with read latency 1 and
// one with read latency 3, driven from a shared vector table plus corner sequences.
module tb_ysyx_22050710_axil_sram;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        awvalid[2], awready[2], wvalid[2], wready[2];
  logic        bvalid[2], bready[2], arvalid[2], arready[2];
  logic        rvalid[2], rready[2], wstate[2];
  logic [31:0] awaddr[2], araddr[2];
  logic [63:0] wdata[2], rdata[2];
  logic [7:0]  wstrb[2];
  logic [1:0]  bresp[2], rresp[2], rstate[2];

  ysyx_22050710_axil_sram #(.READ_LATENCY(1)) dut_l1 (
    .i_aclk(clk), .i_arst(rst),
    .i_awvalid(awvalid[0]), .o_awready(awready[0]), .i_awaddr(awaddr[0]), .i_awprot(3'b000),
    .i_wvalid(wvalid[0]), .o_wready(wready[0]), .i_wdata(wdata[0]), .i_wstrb(wstrb[0]),
    .o_bvalid(bvalid[0]), .i_bready(bready[0]), .o_bresp(bresp[0]),
    .i_arvalid(arvalid[0]), .o_arready(arready[0]), .i_araddr(araddr[0]), .i_arprot(3'b000),
    .o_rvalid(rvalid[0]), .i_rready(rready[0]), .o_rdata(rdata[0]), .o_rresp(rresp[0]),
    .o_dbg_wstate(wstate[0]), .o_dbg_rstate(rstate[0])
  );

  ysyx_22050710_axil_sram #(.READ_LATENCY(3)) dut_l3 (
    .i_aclk(clk), .i_arst(rst),
    .i_awvalid(awvalid[1]), .o_awready(awready[1]), .i_awaddr(awaddr[1]), .i_awprot(3'b000),
    .i_wvalid(wvalid[1]), .o_wready(wready[1]), .i_wdata(wdata[1]), .i_wstrb(wstrb[1]),
    .o_bvalid(bvalid[1]), .i_bready(bready[1]), .o_bresp(bresp[1]),
    .i_arvalid(arvalid[1]), .o_arready(arready[1]), .i_araddr(araddr[1]), .i_arprot(3'b000),
    .o_rvalid(rvalid[1]), .i_rready(rready[1]), .o_rdata(rdata[1]), .o_rresp(rresp[1]),
    .o_dbg_wstate(wstate[1]), .o_dbg_rstate(rstate[1])
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int d, input logic [31:0] a, input logic [63:0] data,
                          input logic [7:0] strb, output logic [1:0] resp, output int lat);
    int n = 0;
    while (!(awready[d] && wready[d]) && n < 10) begin
      step();
      n++;
    end
    awvalid[d] = 1'b1; awaddr[d] = a;
    wvalid[d]  = 1'b1; wdata[d]  = data; wstrb[d] = strb;
    step();
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    lat = 1;
    while (!bvalid[d] && lat < 10) begin
      step();
      lat++;
    end
    resp = bresp[d];
    bready[d] = 1'b1;
    step();
    bready[d] = 1'b0;
  endtask

  task automatic do_read(input int d, input logic [31:0] a, output logic [63:0] data,
                         output logic [1:0] resp, output int lat);
    int n = 0;
    while (!arready[d] && n < 10) begin
      step();
      n++;
    end
    arvalid[d] = 1'b1; araddr[d] = a;
    step();
    arvalid[d] = 1'b0;
    lat = 1;
    while (!rvalid[d] && lat < 10) begin
      step();
      lat++;
    end
    data = rdata[d];
    resp = rresp[d];
    rready[d] = 1'b1;
    step();
    rready[d] = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got_d;
    logic [1:0]  got_r;
    int          lat, n;

    for (int d = 0; d < 2; d++) begin
      awvalid[d] = 0; wvalid[d] = 0; bready[d] = 0; arvalid[d] = 0; rready[d] = 0;
      awaddr[d] = '0; araddr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
    end

    vecs[0]  = '{1'b1, 32'h8000_0008, 64'h1122334455667788, 8'hFF, 64'h0, 2'b00};
    vecs[1]  = '{1'b0, 32'h8000_0008, 64'h0, 8'h00, 64'h1122334455667788, 2'b00};
    vecs[2]  = '{1'b1, 32'h8000_0010, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 2'b00};
    vecs[3]  = '{1'b1, 32'h8000_0010, 64'h0, 8'h0F, 64'h0, 2'b00};
    vecs[4]  = '{1'b0, 32'h8000_0010, 64'h0, 8'h00, 64'hFFFFFFFF00000000, 2'b00};
    vecs[5]  = '{1'b1, 32'h8000_1FF8, 64'hA5A5A5A55A5A5A5A, 8'hFF, 64'h0, 2'b00};
    vecs[6]  = '{1'b1, 32'h7FFF_FFF8, 64'hDEADBEEFDEADBEEF, 8'hFF, 64'h0, 2'b10};
    vecs[7]  = '{1'b0, 32'h8000_1FF8, 64'h0, 8'h00, 64'hA5A5A5A55A5A5A5A, 2'b00};
    vecs[8]  = '{1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00, 64'h0, 2'b10};
    vecs[9]  = '{1'b1, 32'h8000_0000, 64'h0F0F0F0F0F0F0F0F, 8'hFF, 64'h0, 2'b00};
    vecs[10] = '{1'b0, 32'h8000_2000, 64'h0, 8'h00, 64'h0, 2'b10};
    vecs[11] = '{1'b0, 32'h8000_0000, 64'h0, 8'h00, 64'h0F0F0F0F0F0F0F0F, 2'b00};
    vecs[12] = '{1'b1, 32'h8000_000C, 64'hAABBCCDDEEFF0011, 8'hF0, 64'h0, 2'b00};
    vecs[13] = '{1'b0, 32'h8000_000B, 64'h0, 8'h00, 64'hAABBCCDD55667788, 2'b00};
    vecs[14] = '{1'b1, 32'h8000_0008, 64'h0123456789ABCDEF, 8'h00, 64'h0, 2'b00};
    vecs[15] = '{1'b0, 32'h8000_0008, 64'h0, 8'h00, 64'hAABBCCDD55667788, 2'b00};

    // reset state
    repeat (3) step();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst d%0d rvalid", d),  64'(rvalid[d]),  64'd0);
      check($sformatf("rst d%0d bvalid", d),  64'(bvalid[d]),  64'd0);
      check($sformatf("rst d%0d rdata", d),   rdata[d],        64'd0);
      check($sformatf("rst d%0d rresp", d),   64'(rresp[d]),   64'd0);
      check($sformatf("rst d%0d bresp", d),   64'(bresp[d]),   64'd0);
      check($sformatf("rst d%0d arready", d), 64'(arready[d]), 64'd1);
      check($sformatf("rst d%0d awready", d), 64'(awready[d]), 64'd1);
      check($sformatf("rst d%0d wready", d),  64'(wready[d]),  64'd1);
      check($sformatf("rst d%0d rstate", d),  64'(rstate[d]),  64'd0);
      check($sformatf("rst d%0d wstate", d),  64'(wstate[d]),  64'd0);
    end

    // table vectors on both latency variants
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        if (vecs[i].is_wr) begin
          do_write(d, vecs[i].addr, vecs[i].data, vecs[i].strb, got_r, lat);
          check($sformatf("v%0d d%0d bresp", i, d), 64'(got_r), 64'(vecs[i].exp_resp));
          check($sformatf("v%0d d%0d blat", i, d),  64'(lat),   64'd1);
        end else begin
          exp_q.push_back(vecs[i].exp_data);
          do_read(d, vecs[i].addr, got_d, got_r, lat);
          check($sformatf("v%0d d%0d rdata", i, d), got_d, exp_q.pop_front());
          check($sformatf("v%0d d%0d rresp", i, d), 64'(got_r), 64'(vecs[i].exp_resp));
          check($sformatf("v%0d d%0d rlat", i, d),  64'(lat), (d == 0) ? 64'd1 : 64'd3);
        end
      end
    end

    // W three cycles ahead of AW, bvalid held while bready low
    check("wfirst wready_pre", 64'(wready[0]), 64'd1);
    wvalid[0] = 1'b1; wdata[0] = 64'h0102030405060708; wstrb[0] = 8'hFF;
    step();
    wvalid[0] = 1'b0;
    check("wfirst wready_drop", 64'(wready[0]), 64'd0);
    check("wfirst awready", 64'(awready[0]), 64'd1);
    step(); step();
    check("wfirst no_early_b", 64'(bvalid[0]), 64'd0);
    awvalid[0] = 1'b1; awaddr[0] = 32'h8000_0018;
    step();
    awvalid[0] = 1'b0;
    check("wfirst bvalid", 64'(bvalid[0]), 64'd1);
    check("wfirst bresp", 64'(bresp[0]), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("wfirst hold%0d bvalid", c), 64'(bvalid[0]), 64'd1);
      check($sformatf("wfirst hold%0d ready", c), 64'({awready[0], wready[0]}), 64'd0);
    end
    bready[0] = 1'b1;
    step();
    bready[0] = 1'b0;
    check("wfirst bvalid_clr", 64'(bvalid[0]), 64'd0);
    check("wfirst ready_back", 64'({awready[0], wready[0]}), 64'd3);
    do_read(0, 32'h8000_0018, got_d, got_r, lat);
    check("wfirst readback", got_d, 64'h0102030405060708);

    // latency 3 with rready held low
    arvalid[1] = 1'b1; araddr[1] = 32'h8000_0008;
    step();
    arvalid[1] = 1'b0;
    n = 1;
    while (!rvalid[1] && n < 10) begin
      step();
      n++;
    end
    check("lat3 rvalid_lat", 64'(n), 64'd3);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("lat3 hold%0d rdata", c),   rdata[1],        64'hAABBCCDD55667788);
      check($sformatf("lat3 hold%0d rvalid", c),  64'(rvalid[1]),  64'd1);
      check($sformatf("lat3 hold%0d arready", c), 64'(arready[1]), 64'd0);
      step();
    end
    rready[1] = 1'b1;
    step();
    rready[1] = 1'b0;
    check("lat3 rvalid_clr", 64'(rvalid[1]), 64'd0);
    check("lat3 arready", 64'(arready[1]), 64'd1);
    check("lat3 rdata_clr", rdata[1], 64'd0);

    // same-edge write commit and read of one word
    do_write(0, 32'h8000_0020, 64'hA, 8'hFF, got_r, lat);
    check("coll ready", 64'({awready[0], wready[0], arready[0]}), 64'd7);
    awvalid[0] = 1'b1; awaddr[0] = 32'h8000_0020;
    wvalid[0]  = 1'b1; wdata[0]  = 64'hB; wstrb[0] = 8'hFF;
    arvalid[0] = 1'b1; araddr[0] = 32'h8000_0020;
    step();
    awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[0] = 1'b0;
    check("coll rvalid", 64'(rvalid[0]), 64'd1);
    check("coll bvalid", 64'(bvalid[0]), 64'd1);
    check("coll old_data", rdata[0], 64'hA);
    rready[0] = 1'b1; bready[0] = 1'b1;
    step();
    rready[0] = 1'b0; bready[0] = 1'b0;
    do_read(0, 32'h8000_0020, got_d, got_r, lat);
    check("coll new_data", got_d, 64'hB);

    // reset while the latency-3 read is waiting
    arvalid[1] = 1'b1; araddr[1] = 32'h8000_0008;
    step();
    arvalid[1] = 1'b0;
    check("rstwait rstate", 64'(rstate[1]), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstwait rvalid", 64'(rvalid[1]), 64'd0);
    check("rstwait arready", 64'(arready[1]), 64'd1);
    repeat (4) step();
    check("rstwait rvalid_later", 64'(rvalid[1]), 64'd0);

    // a commit edge coinciding with reset leaves memory alone
    do_write(0, 32'h8000_0028, 64'h1111, 8'hFF, got_r, lat);
    awvalid[0] = 1'b1; awaddr[0] = 32'h8000_0028;
    wvalid[0]  = 1'b1; wdata[0]  = 64'h2222; wstrb[0] = 8'hFF;
    rst = 1'b1;
    step();
    rst = 1'b0; awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    check("rstwr bvalid", 64'(bvalid[0]), 64'd0);
    check("rstwr awready", 64'(awready[0]), 64'd1);
    do_read(0, 32'h8000_0028, got_d, got_r, lat);
    check("rstwr mem_kept", got_d, 64'h1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_axil_sram.md
Name: ysyx_22050710_axil_sram

Overview:
Parametrised AXI-lite slave SRAM with an internal register-array memory and full read and write channels. It is the general-purpose successor to the read-only instruction SRAM wrapper, usable as instruction or data memory behind the core's AXI-lite masters. Adds byte-strobed writes, configurable read latency and SLVERR on out-of-range addresses.

Parameters:
DATA_WIDTH, 64, data bus width in bits (32 or 64)
ADDR_WIDTH, 32, address bus width in bits
STRB_WIDTH, DATA_WIDTH/8, write strobe width
DEPTH, 1024, memory depth in DATA_WIDTH words (power of 2)
BASE_ADDR, 32'h8000_0000, byte address of word 0
READ_LATENCY, 1, cycles from ar handshake to o_rvalid (1..4)

Ports:
i_aclk  in  1  clock, all logic on rising edge
i_arst  in  1  synchronous active-high reset
i_awvalid/o_awready  in/out  1/1  write address handshake
i_awaddr  in  ADDR_WIDTH  write byte address
i_awprot  in  3  accepted, ignored
i_wvalid/o_wready  in/out  1/1  write data handshake
i_wdata  in  DATA_WIDTH  write data
i_wstrb  in  STRB_WIDTH  byte enables, bit k -> byte k
o_bvalid/i_bready  out/in  1/1  write response handshake
o_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
i_arvalid/o_arready  in/out  1/1  read address handshake
i_araddr  in  ADDR_WIDTH  read byte address
i_arprot  in  3  accepted, ignored
o_rvalid/i_rready  out/in  1/1  read data handshake
o_rdata  out  DATA_WIDTH  read data
o_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR

Behaviour:
- Reset (i_arst=1 at clock edge): both FSMs to IDLE, capture flags cleared. o_rvalid, o_bvalid, o_rdata, o_rresp, o_bresp = 0. o_arready = 1, o_awready = 1 and o_wready = 1 from the first cycle after reset. Memory contents are not reset.
- Reset mid-operation: the in-flight transaction is dropped with no response. A write whose commit edge coincides with reset does not modify memory.
- Address decode: word index = (addr - BASE_ADDR) >> log2(STRB_WIDTH). Low byte-offset bits are ignored (no misalignment error). In range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH*STRB_WIDTH; otherwise SLVERR.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE: o_awready = !aw_captured and o_wready = !w_captured. AW and W are accepted independently, in either order or in the same cycle, and latched into capture registers.
  - Commit edge: the edge at which both are held, counting a handshake in that cycle. On this edge, bytes with i_wstrb=1 are written (in range only), bresp is set and the FSM enters W_RESP. o_bvalid=1 the next cycle.
  - Out-of-range write: memory is unchanged and bresp = 2'b10.
  - In W_RESP: awready = wready = 0. The FSM holds o_bvalid and o_bresp until i_bready, then clears the capture flags and returns to W_IDLE.
  - wstrb = 0: no bytes change, response OKAY.
- Read FSM, states R_IDLE, R_WAIT and R_RESP:
  - o_arready = (state == R_IDLE).
  - On the ar handshake edge, the addressed word (old value) and rresp are registered. Out-of-range reads return rdata 0 and rresp 2'b10.
  - READ_LATENCY = 1: go to R_RESP, with o_rvalid the cycle after the handshake.
  - Otherwise: go to R_WAIT with a counter of READ_LATENCY-1 and enter R_RESP when it reaches 0. o_rvalid is asserted exactly READ_LATENCY cycles after the handshake.
  - In R_RESP: o_rdata and o_rresp are held stable while o_rvalid && !i_rready. On the r handshake, return to R_IDLE and clear o_rdata to 0.
  - Back-to-back reads: the next ar is accepted one cycle after the r handshake, giving a minimum period of READ_LATENCY+1.
- Read and write FSMs are fully independent and may be active concurrently.
- Read/write collision: if the ar handshake edge equals a write commit edge to the same word, the read returns the pre-write data. A read issued on any later edge sees the new data.

Test Plan:
- Reset then write 0x1122334455667788 to 0x80000008 with strb 0xFF (AW and W same cycle) -> o_bvalid one cycle after handshake, bresp 00. Read 0x80000008 -> o_rdata 0x1122334455667788, rresp 00, o_rvalid READ_LATENCY cycles after ar.
- W presented 3 cycles before AW -> o_wready drops after the W handshake. Commit occurs on the AW edge, and bvalid is held 4 cycles with i_bready low until released.
- Partial strobe: word holds 0xFFFF_FFFF_FFFF_FFFF, write 0 with strb 0x0F -> readback 0xFFFFFFFF00000000.
- Out of range: write to 0x7FFFFFF8 -> bresp 10 with memory unchanged. Read BASE_ADDR+DEPTH*8 -> rdata 0, rresp 10.
- READ_LATENCY=3 with i_rready low 5 cycles -> rvalid 3 cycles after ar, rdata stable throughout, arready 0 until the r handshake.
- Same-edge write commit and read of one word (old 0xA, new 0xB) -> read returns 0xA. Next read returns 0xB. Also assert i_arst during R_WAIT -> rvalid stays 0 and arready=1 after reset.
